// File: rtl/sum_acc_pkg.sv
// Shared types and default widths for the burst sum accumulator.
package sum_acc_pkg;

  localparam int unsigned DATA_W_DEF = 32;
  localparam int unsigned CNT_W_DEF  = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ACCUM = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  // Unsigned carry-out of a+b recovered from operand and sum MSBs.
  function automatic logic add_cout(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb & b_msb) | ((a_msb | b_msb) & ~s_msb);
  endfunction

endpackage

// File: rtl/brent_kung_adder.sv
// Parallel-prefix (Brent-Kung) adder, no carry-in or carry-out.
module brent_kung_adder #(
  parameter int unsigned W = 32
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  output logic [W-1:0] sum
);

  localparam int unsigned LOG = $clog2(W);

  logic [W-1:0] p0;
  logic [W-1:0] gg;
  logic [W-1:0] pp;

  // Up-sweep builds group terms at power-of-two spans, down-sweep fills the gaps.
  always_comb begin
    p0 = a ^ b;
    gg = a & b;
    pp = p0;
    for (int l = 0; l < int'(LOG); l++) begin
      for (int i = 0; i < int'(W); i++) begin
        if (((i + 1) % (1 << (l + 1))) == 0) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    for (int l = int'(LOG) - 2; l >= 0; l--) begin
      for (int i = 0; i < int'(W); i++) begin
        if ((i >= (1 << (l + 1))) && (((i + 1) % (1 << (l + 1))) == (1 << l))) begin
          gg[i] = gg[i] | (pp[i] & gg[i - (1 << l)]);
          pp[i] = pp[i] & pp[i - (1 << l)];
        end
      end
    end
    sum = p0 ^ {gg[W-2:0], 1'b0};
  end

endmodule

// File: rtl/sum_accumulator.sv
// Burst accumulator: sums len words from a valid/ready stream and presents the
// total with a sticky unsigned-overflow flag.
module sum_accumulator
  import sum_acc_pkg::*;
#(
  parameter int unsigned DATA_W = DATA_W_DEF,
  parameter int unsigned CNT_W  = CNT_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [CNT_W-1:0]  len,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_sum,
  output logic              out_carry,
  output logic              busy
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] acc_q, acc_d;
  logic              carry_q, carry_d;
  logic [CNT_W-1:0]  rem_q, rem_d;
  logic              in_ready_q, out_valid_q, busy_q;
  logic [DATA_W-1:0] add_sum;
  logic              add_co;

  brent_kung_adder #(.W(DATA_W)) u_adder (
    .a   (acc_q),
    .b   (in_data),
    .sum (add_sum)
  );

  assign add_co = add_cout(acc_q[DATA_W-1], in_data[DATA_W-1], add_sum[DATA_W-1]);

  // Next-state and datapath update.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    carry_d = carry_q;
    rem_d   = rem_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          acc_d   = '0;
          carry_d = 1'b0;
          rem_d   = len;
          state_d = (len == '0) ? ST_DONE : ST_ACCUM;
        end
      end
      ST_ACCUM: begin
        if (in_valid) begin
          acc_d   = add_sum;
          carry_d = carry_q | add_co;
          rem_d   = rem_q - CNT_W'(1);
          if (rem_q == CNT_W'(1)) state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (out_ready) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Handshake/status flags are registered from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      acc_q       <= '0;
      carry_q     <= 1'b0;
      rem_q       <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      acc_q       <= acc_d;
      carry_q     <= carry_d;
      rem_q       <= rem_d;
      in_ready_q  <= (state_d == ST_ACCUM);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign out_sum   = acc_q;
  assign out_carry = carry_q;

endmodule

// File: tb/tb_sum_accumulator.sv
// Directed bench for sum_accumulator with hand-computed expected results.
module tb_sum_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic [7:0]  len;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_sum;
  logic        out_carry;
  logic        busy;

  int checks = 0;
  int errors = 0;
  int beats;

  sum_accumulator dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .len       (len),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_sum   (out_sum),
    .out_carry (out_carry),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle_zero(input string tag);
    chk({tag, "_in_ready"}, 32'(in_ready), 32'd0);
    chk({tag, "_out_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_busy"}, 32'(busy), 32'd0);
    chk({tag, "_out_sum"}, out_sum, 32'd0);
    chk({tag, "_out_carry"}, 32'(out_carry), 32'd0);
  endtask

  task automatic handshake(input string tag);
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
    chk({tag, "_idle_valid"}, 32'(out_valid), 32'd0);
    chk({tag, "_idle_busy"}, 32'(busy), 32'd0);
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; len = '0; in_valid = 1'b0;
    in_data = '0; out_ready = 1'b0;
    step(); step();
    chk_idle_zero("reset");
    rst_n = 1'b1;

    // Burst of 1,2,3.
    start = 1'b1; len = 8'd3;
    step();
    start = 1'b0;
    chk("s1_in_ready", 32'(in_ready), 32'd1);
    chk("s1_busy", 32'(busy), 32'd1);
    in_valid = 1'b1; in_data = 32'd1; step();
    in_data = 32'd2; step();
    in_data = 32'd3;
    chk("s1_valid_before_last", 32'(out_valid), 32'd0);
    step();
    in_valid = 1'b0;
    chk("s1_out_valid", 32'(out_valid), 32'd1);
    chk("s1_in_ready_done", 32'(in_ready), 32'd0);
    chk("s1_sum", out_sum, 32'd6);
    chk("s1_carry", 32'(out_carry), 32'd0);
    handshake("s1");
    chk("s1_sum_hold", out_sum, 32'd6);

    // Wrap with carry.
    start = 1'b1; len = 8'd2; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; step();
    in_data = 32'h0000_0002; step();
    in_valid = 1'b0;
    chk("s2_out_valid", 32'(out_valid), 32'd1);
    chk("s2_sum", out_sum, 32'h0000_0001);
    chk("s2_carry", 32'(out_carry), 32'd1);
    handshake("s2");

    // Sticky carry across a later non-overflowing beat.
    start = 1'b1; len = 8'd3; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'hFFFF_FFFF; step();
    in_data = 32'd2; step();
    in_data = 32'd5; step();
    in_valid = 1'b0;
    chk("s2b_sum", out_sum, 32'd6);
    chk("s2b_carry", 32'(out_carry), 32'd1);
    handshake("s2b");

    // Zero-length burst.
    start = 1'b1; len = 8'd0; step(); start = 1'b0;
    chk("s3_out_valid", 32'(out_valid), 32'd1);
    chk("s3_in_ready", 32'(in_ready), 32'd0);
    chk("s3_sum", out_sum, 32'd0);
    chk("s3_carry", 32'(out_carry), 32'd0);
    handshake("s3");

    // Gapped input, stalled output, start ignored in DONE.
    start = 1'b1; len = 8'd4; step(); start = 1'b0;
    beats = 0;
    for (int k = 0; k < 20 && !out_valid; k++) begin
      in_valid = (k % 2 == 0);
      in_data = 32'(10 * (beats + 1));
      if (in_valid && in_ready) beats++;
      step();
    end
    in_valid = 1'b0;
    chk("s4_out_valid", 32'(out_valid), 32'd1);
    chk("s4_beats", 32'(beats), 32'd4);
    for (int k = 0; k < 5; k++) begin
      start = (k % 2 == 0); len = 8'd1;
      step();
      chk("s4_hold_valid", 32'(out_valid), 32'd1);
      chk("s4_hold_sum", out_sum, 32'd100);
      chk("s4_hold_in_ready", 32'(in_ready), 32'd0);
    end
    start = 1'b1; len = 8'd5; out_ready = 1'b1;
    step();
    start = 1'b0; out_ready = 1'b0;
    chk("s4_start_on_hs_busy", 32'(busy), 32'd0);
    chk("s4_start_on_hs_ready", 32'(in_ready), 32'd0);
    chk("s4_sum_after_hs", out_sum, 32'd100);

    // Reset mid-burst, then a fresh one-word burst.
    start = 1'b1; len = 8'd5; step(); start = 1'b0;
    in_valid = 1'b1; in_data = 32'd1; step();
    in_data = 32'd2; step();
    in_data = 32'd4;
    #2 rst_n = 1'b0;
    #1;
    chk_idle_zero("s5_rst");
    in_valid = 1'b0;
    step();
    chk_idle_zero("s5_rst_held");
    rst_n = 1'b1;
    start = 1'b1; len = 8'd1;
    step();
    start = 1'b0;
    chk("s5_in_ready", 32'(in_ready), 32'd1);
    in_valid = 1'b1; in_data = 32'd7; step();
    in_valid = 1'b0;
    chk("s5_out_valid", 32'(out_valid), 32'd1);
    chk("s5_sum", out_sum, 32'd7);
    chk("s5_carry", 32'(out_carry), 32'd0);
    handshake("s5");

    // Maximum length burst.
    start = 1'b1; len = 8'd255; step(); start = 1'b0;
    beats = 0;
    in_valid = 1'b1; in_data = 32'h0100_0000;
    for (int k = 0; k < 300 && !out_valid; k++) begin
      if (in_ready) beats++;
      step();
    end
    chk("s6_out_valid", 32'(out_valid), 32'd1);
    step();
    in_valid = 1'b0;
    chk("s6_beats", 32'(beats), 32'd255);
    chk("s6_sum", out_sum, 32'hFF00_0000);
    chk("s6_carry", 32'(out_carry), 32'd0);
    handshake("s6");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
